// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/decode/execute sequencer: state codes and opcode decode.
package fetch_sequencer_pkg;

    localparam int unsigned OPC_HI = 7;
    localparam int unsigned OPC_LO = 5;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_TGT    = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;
    localparam logic [2:0] OP_HLT = 3'b101;

    function automatic logic [2:0] opcode_of(input logic [7:0] b);
        return b[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute controller: fetches instruction bytes, resolves
// JMP/JZ locally, hands other opcodes to the datapath, supports HALT and a bus timeout.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned ACK_TO = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc_value,
    output logic          pc_inc,
    output logic          pc_load,
    output logic [DW-1:0] pc_load_val,
    output logic          mem_req,
    output logic [DW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir,
    output logic          exec_start,
    input  logic          exec_done,
    input  logic          zero_flag,
    input  logic          resume,
    output logic          halted,
    output logic          fault
);

    localparam int unsigned CW = 4;

    logic [2:0]    state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    opc;
    logic          cnt_expired;

    assign opc         = opcode_of(ir_q[7:0]);
    assign cnt_expired = (cnt_q == CW'(ACK_TO - 1));
    assign ir          = rst ? '0 : ir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter runs only while an awaited ack/done is low; any exit clears it.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = '0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        exec_start  = 1'b0;
        halted      = 1'b0;
        fault       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_value;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_expired) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                if (opc == OP_HLT) begin
                    state_d = S_HALT;
                end else if (opc == OP_JMP || opc == OP_JZ) begin
                    state_d = S_TGT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_TGT: begin
                mem_req  = 1'b1;
                mem_addr = pc_value;
                if (mem_ack) begin
                    if (opc == OP_JMP || zero_flag) begin
                        pc_load     = 1'b1;
                        pc_load_val = mem_rdata;
                    end else begin
                        pc_inc = 1'b1;
                    end
                    state_d = S_FETCH;
                end else if (cnt_expired) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_EXEC: begin
                exec_start = 1'b1;
                if (exec_done) begin
                    state_d = S_FETCH;
                end else if (cnt_expired) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset forces every output low within the reset cycle itself.
        if (rst) begin
            pc_inc      = 1'b0;
            pc_load     = 1'b0;
            pc_load_val = '0;
            mem_req     = 1'b0;
            mem_addr    = '0;
            exec_start  = 1'b0;
            halted      = 1'b0;
            fault       = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized program
// run checked against an instruction-level model of the core.
module tb_fetch_sequencer;

    localparam int K_OPC  = 0;
    localparam int K_TGT  = 1;
    localparam int K_EXEC = 2;
    localparam int K_HALT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc_value;
    logic       pc_inc, pc_load;
    logic [7:0] pc_load_val;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [7:0] ir;
    logic       exec_start, exec_done, zero_flag, resume, halted, fault;

    logic [7:0] mem [0:255];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Program-counter register the sequencer controls.
    always @(posedge clk) begin
        if (rst)          pc_value <= 8'h00;
        else if (pc_load) pc_value <= pc_load_val;
        else if (pc_inc)  pc_value <= pc_value + 8'h01;
    end

    assign mem_rdata = mem[mem_addr];

    fetch_sequencer #(.DW(8), .ACK_TO(15)) dut (
        .clk(clk), .rst(rst), .pc_value(pc_value),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ir(ir), .exec_start(exec_start), .exec_done(exec_done), .zero_flag(zero_flag),
        .resume(resume), .halted(halted), .fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ack, input logic done,
                         input logic zf, input logic res);
        @(negedge clk);
        rst = r; mem_ack = ack; exec_done = done; zero_flag = zf; resume = res;
        #1;
    endtask

    initial begin : main
        int n;
        int m_kind, idle, ack_wait, done_wait;
        logic [7:0] m_pc, m_ir, tgt;
        logic [2:0] op;
        logic taken;

        rst = 1'b1; mem_ack = 1'b0; exec_done = 1'b0; zero_flag = 1'b0; resume = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h20; mem[8'h01] = 8'hC0; mem[8'h02] = 8'h3A;
        mem[8'h3A] = 8'hE0; mem[8'h3B] = 8'h55;
        mem[8'h55] = 8'hE0; mem[8'h56] = 8'h77; mem[8'h57] = 8'hA0;

        // Reset and one EXEC-class instruction
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ir", 32'(ir), 32'd0);
        check("rst_pc_inc", 32'(pc_inc), 32'd0);
        drive(0, 1, 0, 0, 0);
        check("t1_req", 32'(mem_req), 32'd1);
        check("t1_addr", 32'(mem_addr), 32'h00);
        check("t1_pc_inc", 32'(pc_inc), 32'd1);
        drive(0, 0, 0, 0, 0);
        check("t1_decode_req", 32'(mem_req), 32'd0);
        check("t1_ir", 32'(ir), 32'h20);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, i == 2, 0, 0);
            if (exec_start) n++;
        end
        check("t1_exec_cycles", 32'(n), 32'd3);
        drive(0, 0, 0, 0, 0);
        check("t1_back_fetch", 32'(mem_req), 32'd1);
        check("t1_pc", 32'(pc_value), 32'h01);

        // JMP 3A
        drive(0, 1, 0, 0, 0);
        check("t2_pc_inc", 32'(pc_inc), 32'd1);
        drive(0, 0, 0, 0, 0);
        check("t2_ir", 32'(ir), 32'hC0);
        drive(0, 1, 0, 0, 0);
        check("t2_addr", 32'(mem_addr), 32'h02);
        check("t2_pc_load", 32'(pc_load), 32'd1);
        check("t2_load_val", 32'(pc_load_val), 32'h3A);
        check("t2_no_inc", 32'(pc_inc), 32'd0);
        drive(0, 0, 0, 0, 0);
        check("t2_pc", 32'(pc_value), 32'h3A);

        // JZ taken then not taken
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0);
        check("t3_jz1_load", 32'(pc_load), 32'd1);
        check("t3_jz1_val", 32'(pc_load_val), 32'h55);
        check("t3_jz1_inc", 32'(pc_inc), 32'd0);
        drive(0, 0, 0, 0, 0);
        check("t3_pc55", 32'(pc_value), 32'h55);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 0);
        check("t3_jz0_inc", 32'(pc_inc), 32'd1);
        check("t3_jz0_load", 32'(pc_load), 32'd0);
        drive(0, 0, 0, 0, 0);
        check("t3_pc57", 32'(pc_value), 32'h57);

        // HLT and resume, with stray acks/done/resume-less cycles ignored
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("t4_decode_halted", 32'(halted), 32'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, 0, 0);
            if (halted && !mem_req && !exec_start) n++;
        end
        check("t4_halt_cycles", 32'(n), 32'd10);
        check("t4_pc_hold", 32'(pc_value), 32'h58);
        drive(0, 0, 0, 0, 1);
        check("t4_resume_cycle", 32'(halted), 32'd1);
        drive(0, 0, 0, 0, 0);
        check("t4_req_after", 32'(mem_req), 32'd1);
        check("t4_addr", 32'(mem_addr), 32'h58);

        // Bus timeout: 15 waiting cycles then sticky fault
        n = 1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, 0);
            if (mem_req) n++;
        end
        check("t5_wait_cycles", 32'(n), 32'd15);
        check("t5_fault", 32'(fault), 32'd1);
        check("t5_req", 32'(mem_req), 32'd0);
        drive(0, 1, 1, 0, 1);
        check("t5_sticky", 32'(fault), 32'd1);
        check("t5_sticky_inc", 32'(pc_inc), 32'd0);
        drive(1, 0, 0, 0, 0);
        check("t5_rst_fault", 32'(fault), 32'd0);
        drive(0, 0, 0, 0, 0);
        check("t5_after_rst_req", 32'(mem_req), 32'd1);
        check("t5_after_rst_fault", 32'(fault), 32'd0);
        check("t5_after_rst_addr", 32'(mem_addr), 32'h00);

        // Ack on the last allowed waiting cycle wins over the timeout
        mem[8'h00] = 8'h40;
        for (int i = 0; i < 13; i++) drive(0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        check("tb_ack_wins_inc", 32'(pc_inc), 32'd1);
        check("tb_ack_wins_fault", 32'(fault), 32'd0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        check("tb_exec", 32'(exec_start), 32'd1);

        // Reset while TGT is requesting; the concurrent ack is discarded
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 0);
        check("t6_req", 32'(mem_req), 32'd0);
        check("t6_load", 32'(pc_load), 32'd0);
        check("t6_inc", 32'(pc_inc), 32'd0);
        drive(0, 0, 0, 0, 0);
        check("t6_req_after", 32'(mem_req), 32'd1);
        check("t6_addr", 32'(mem_addr), 32'h00);

        // Randomized program against an instruction-level model
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        drive(1, 0, 0, 0, 0);
        m_pc = 8'h00; m_ir = 8'h00; m_kind = K_OPC; idle = 0;
        ack_wait = 0; done_wait = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = 1'b0;
            if (mem_req) begin
                if (ack_wait == 0) begin
                    mem_ack = 1'b1; ack_wait = $urandom_range(0, 4);
                end else begin
                    mem_ack = 1'b0; ack_wait--;
                end
            end else begin
                mem_ack = ($urandom_range(0, 7) == 0);
            end
            if (exec_start) begin
                if (done_wait == 0) begin
                    exec_done = 1'b1; done_wait = $urandom_range(0, 4);
                end else begin
                    exec_done = 1'b0; done_wait--;
                end
            end else begin
                exec_done = ($urandom_range(0, 7) == 0);
            end
            zero_flag = 1'($urandom_range(0, 1));
            resume = ($urandom_range(0, 3) == 0);
            #1;

            idle++;
            check("r_ir", 32'(ir), 32'(m_ir));
            check("r_fault", 32'(fault), 32'd0);
            if (mem_req && mem_ack) begin
                idle = 0;
                check("r_addr", 32'(mem_addr), 32'(m_pc));
                if (m_kind == K_OPC) begin
                    check("r_opc_inc", 32'({pc_inc, pc_load}), 32'b10);
                    m_ir = mem[m_pc];
                    m_pc = m_pc + 8'h01;
                    op = m_ir[7:5];
                    if (op == 3'b110 || op == 3'b111) m_kind = K_TGT;
                    else if (op == 3'b101)            m_kind = K_HALT;
                    else                              m_kind = K_EXEC;
                end else begin
                    check("r_req_kind", 32'(m_kind), 32'(K_TGT));
                    op = m_ir[7:5];
                    tgt = mem[m_pc];
                    taken = (op == 3'b110) || zero_flag;
                    if (taken) begin
                        check("r_tgt_load", 32'({pc_inc, pc_load}), 32'b01);
                        check("r_tgt_val", 32'(pc_load_val), 32'(tgt));
                        m_pc = tgt;
                    end else begin
                        check("r_tgt_skip", 32'({pc_inc, pc_load}), 32'b10);
                        m_pc = m_pc + 8'h01;
                    end
                    m_kind = K_OPC;
                end
            end else begin
                check("r_strobe_idle", 32'({pc_inc, pc_load}), 32'b00);
            end
            if (exec_start) begin
                check("r_exec_kind", 32'(m_kind), 32'(K_EXEC));
                if (exec_done) begin
                    m_kind = K_OPC; idle = 0;
                end
            end
            if (halted) begin
                check("r_halt_kind", 32'(m_kind), 32'(K_HALT));
                check("r_halt_req", 32'(mem_req), 32'd0);
                if (resume) begin
                    m_kind = K_OPC; idle = 0;
                end
            end
            if (idle > 40) begin
                check("r_stall", 32'(idle), 32'd0);
                break;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
